dac_spi_multi: RTL and testbench

Parametrised multi-channel SPI DAC driver, successor to the single-channel 12-bit DAC block. Accepts samples with a channel/broadcast tag over a valid/ready handshake, buffers one sample while a frame is shifting, and emits 32-bit LTC2624-format frames (8 don't-care, 4-bit command, 4-bit address, 16-bit left-justified data) over mode-0 SPI at a divided clock. Sits between the synth voice mixer and the board DAC pins.

---
 rtl/dac_spi_pkg.sv | 21 ++
 rtl/dac_spi_sck_gen.sv | 42 ++++
 rtl/dac_spi_multi.sv | 165 ++++++++++++++++
 tb/tb_dac_spi_multi.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared types and frame assembly for the multi-channel LTC2624-style SPI DAC driver.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } dac_state_t;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] ADDR_ALL         = 4'b1111;
  localparam int         FRAME_BITS       = 32;

  // 8 don't-care bits (driven 0), command, address, left-justified 16-bit data
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0]  addr,
                                                        input logic [15:0] data);
    return {8'h00, CMD_WRITE_UPDATE, addr, data};
  endfunction

endpackage

// File: rtl/dac_spi_sck_gen.sv
// SCK generator: CLK_DIV cycles per half-period, idle low, strobes mark the edge
// at which SCK will toggle. Counter is held cleared whenever en is low.
module dac_spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             term;

  // Terminal count of the current half-period selects the toggle edge
  always_comb begin
    term     = en && (cnt == CNT_W'(CLK_DIV - 1));
    sck_rise = term && !sck;
    sck_fall = term && sck;
  end

  // Half-period counter and SCK level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (term) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_multi.sv
// Multi-channel SPI DAC driver: one-entry sample buffer, 32-bit LTC2624 frames,
// mode-0 SPI. Define DAC_SPI_DEBUG_EN to expose OUT_STATE / OUT_WRITE_BIT.
module dac_spi_multi
  import dac_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int CHANNELS   = 4,
  parameter int CLK_DIV    = 2,
  parameter int CLR_CYCLES = 16,
  parameter int CS_GAP     = 2
) (
  input  logic                                          IN_CLOCK,
  input  logic                                          IN_RESET,
  input  logic [DATA_WIDTH-1:0]                         IN_BITS,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] IN_CHANNEL,
  input  logic                                          IN_BROADCAST,
  input  logic                                          IN_SAMPLE_READY,
  output logic                                          OUT_READY,
  output logic                                          OUT_SPI_SCK,
  output logic                                          OUT_SPI_MOSI,
  output logic                                          OUT_DAC_CS,
  output logic                                          OUT_DAC_CLR,
  output logic                                          OUT_BUSY
`ifdef DAC_SPI_DEBUG_EN
  ,
  output logic [1:0]                                    OUT_STATE,
  output logic [5:0]                                    OUT_WRITE_BIT
`endif
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  dac_state_t            state;
  logic [CLR_W-1:0]      clr_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [4:0]            bit_idx;
  logic                  last_half;
  logic [FRAME_BITS-1:0] shreg;
  logic                  cs_q, mosi_q, clr_q;
  logic                  buf_full;
  logic [3:0]            buf_addr;
  logic [15:0]           buf_data;

  logic                  accept, chan_ok, gap_done, drain;
  logic [3:0]            in_addr;
  logic [15:0]           in_data;
  logic [FRAME_BITS-1:0] buf_frame;
  logic                  sck, sck_rise, sck_fall;

  // Handshake decode, address/data justification and buffer drain condition
  always_comb begin
    OUT_READY = (state != ST_CLEAR) && !buf_full;
    OUT_BUSY  = (state != ST_IDLE);
    accept    = IN_SAMPLE_READY && OUT_READY;
    chan_ok   = IN_BROADCAST || (32'(IN_CHANNEL) < 32'(CHANNELS));
    in_addr   = IN_BROADCAST ? ADDR_ALL : 4'(IN_CHANNEL);
    in_data   = 16'(IN_BITS) << (16 - DATA_WIDTH);
    buf_frame = build_frame(buf_addr, buf_data);
    gap_done  = (gap_cnt == GAP_W'(CS_GAP - 1));
    drain     = buf_full && ((state == ST_IDLE) || ((state == ST_GAP) && gap_done));
  end

  dac_spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (IN_CLOCK),
    .rst_n    (IN_RESET),
    .en       ((state == ST_SHIFT) && !cs_q),
    .sck      (sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  assign OUT_SPI_SCK  = sck;
  assign OUT_SPI_MOSI = mosi_q;
  assign OUT_DAC_CS   = cs_q;
  assign OUT_DAC_CLR  = clr_q;

`ifdef DAC_SPI_DEBUG_EN
  assign OUT_STATE     = state;
  assign OUT_WRITE_BIT = ((state == ST_SHIFT) && !cs_q) ? {1'b0, bit_idx} : 6'd0;
`endif

  // Sample buffer plus CLEAR/IDLE/SHIFT/GAP sequencer with registered pin outputs.
  // Entry from IDLE spends one cycle loading with CS still high; entry from GAP
  // loads and drops CS on the same edge so back-to-back gaps are exactly CS_GAP.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET) begin
    if (!IN_RESET) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      gap_cnt   <= '0;
      bit_idx   <= '0;
      last_half <= 1'b0;
      shreg     <= '0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      clr_q     <= 1'b0;
      buf_full  <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      if (accept && chan_ok) begin
        buf_addr <= in_addr;
        buf_data <= in_data;
      end
      buf_full <= (accept && chan_ok) || (buf_full && !drain);

      case (state)
        ST_CLEAR: begin
          if (!clr_q) begin
            if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) clr_q <= 1'b1;
            else                                     clr_cnt <= clr_cnt + 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (buf_full) begin
            shreg <= buf_frame;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_q) begin
            cs_q      <= 1'b0;
            mosi_q    <= shreg[FRAME_BITS-1];
            bit_idx   <= 5'd31;
            last_half <= 1'b0;
          end else begin
            if (sck_rise && (bit_idx == 5'd0)) last_half <= 1'b1;
            if (sck_fall) begin
              if (last_half) begin
                cs_q      <= 1'b1;
                mosi_q    <= 1'b0;
                last_half <= 1'b0;
                gap_cnt   <= '0;
                state     <= ST_GAP;
              end else begin
                mosi_q  <= shreg[bit_idx - 5'd1];
                bit_idx <= bit_idx - 5'd1;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            if (buf_full) begin
              shreg     <= buf_frame;
              cs_q      <= 1'b0;
              mosi_q    <= buf_frame[FRAME_BITS-1];
              bit_idx   <= 5'd31;
              last_half <= 1'b0;
              state     <= ST_SHIFT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_multi.sv
// Directed bench for dac_spi_multi. CHANNELS=5 so that an out-of-range channel
// (5) is expressible on the 3-bit channel port; channel 4 is the last valid one.
module tb_dac_spi_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bits = '0;
  logic [2:0]  chan = '0;
  logic        bcast = 1'b0;
  logic        valid = 1'b0;
  logic        ready, sck, mosi, cs, clr, busy;
`ifdef DAC_SPI_DEBUG_EN
  logic [1:0]  dbg_state;
  logic [5:0]  dbg_bit;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dac_spi_multi #(
    .DATA_WIDTH (12),
    .CHANNELS   (5),
    .CLK_DIV    (2),
    .CLR_CYCLES (16),
    .CS_GAP     (2)
  ) dut (
    .IN_CLOCK        (clk),
    .IN_RESET        (rst_n),
    .IN_BITS         (bits),
    .IN_CHANNEL      (chan),
    .IN_BROADCAST    (bcast),
    .IN_SAMPLE_READY (valid),
    .OUT_READY       (ready),
    .OUT_SPI_SCK     (sck),
    .OUT_SPI_MOSI    (mosi),
    .OUT_DAC_CS      (cs),
    .OUT_DAC_CLR     (clr),
    .OUT_BUSY        (busy)
`ifdef DAC_SPI_DEBUG_EN
    ,
    .OUT_STATE       (dbg_state),
    .OUT_WRITE_BIT   (dbg_bit)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    32'(cs),    32'd1);
    check({tag, "_sck"},   32'(sck),   32'd0);
    check({tag, "_mosi"},  32'(mosi),  32'd0);
    check({tag, "_clr"},   32'(clr),   32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_busy"},  32'(busy),  32'd1);
  endtask

  // Release reset between edges and time the clear sequence in posedges
  task automatic release_and_clear();
    int n, bad;
    n = 0; bad = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (cs !== 1'b1 || sck !== 1'b0) bad++;
      if (clr === 1'b1) break;
    end
    check("clr_low_cycles", 32'(n), 32'd16);
    check("clear_cs_sck_idle", 32'(bad), 32'd0);
    check("ready_at_clr_rise", 32'(ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_clr", 32'(ready), 32'd1);
    check("busy_in_idle", 32'(busy), 32'd0);
  endtask

  // Offer one sample; returns #1 after the handshake edge
  task automatic send(input logic [11:0] b, input logic [2:0] c, input logic bc);
    int w;
    w = 0;
    @(negedge clk);
    bits = b; chan = c; bcast = bc; valid = 1'b1;
    while (ready !== 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
    else @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Sample pins on falling clk: hi = CS-high samples before the frame, low = CS-low
  // cycles, first = cycles from CS fall to first SCK rise. Ends having consumed
  // the first CS-high sample after the frame.
  task automatic capture(output logic [31:0] fr, output int rises, output int low,
                         output int hi, output int first);
    logic prev;
    fr = '0; rises = 0; low = 0; hi = 0; first = -1; prev = 1'b0;
    @(negedge clk);
    while (cs === 1'b1 && hi < 1000) begin
      hi++;
      @(negedge clk);
    end
    if (cs !== 1'b0) begin
      check("cs_fall_timeout", 32'(cs), 32'd0);
      return;
    end
    while (cs === 1'b0 && low < 1000) begin
      low++;
      if (sck === 1'b1 && prev === 1'b0) begin
        rises++;
        fr = {fr[30:0], mosi};
        if (first < 0) first = low - 1;
      end
      prev = sck;
      @(negedge clk);
    end
    if (cs !== 1'b1) check("cs_rise_timeout", 32'(cs), 32'd1);
  endtask

  logic [31:0] fr;
  int rises, low, hi, first, cnt;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    release_and_clear();

    // Channel 2, 0xABC: buffer fills at k, loads at k+1, CS falls at k+2
    send(12'hABC, 3'd2, 1'b0);
    check("ready_buffer_full", 32'(ready), 32'd0);
    @(negedge clk);
    check("cs_before_load", 32'(cs), 32'd1);
    @(negedge clk);
    check("cs_at_load", 32'(cs), 32'd1);
    check("ready_after_drain", 32'(ready), 32'd1);
    capture(fr, rises, low, hi, first);
    check("cs_fall_latency", 32'(hi), 32'd0);
    check("frame_ch2", fr, 32'h0032ABC0);
    check("sck_rises", 32'(rises), 32'd32);
    check("cs_low_cycles", 32'(low), 32'd128);
    check("first_rise_delay", 32'(first), 32'd2);
    repeat (5) @(negedge clk);

    // Broadcast
    send(12'h001, 3'd0, 1'b1);
    capture(fr, rises, low, hi, first);
    check("frame_bcast", fr, 32'h003F0010);
    check("bcast_cs_low", 32'(low), 32'd128);
    check("bcast_latency", 32'(hi), 32'd2);
    repeat (5) @(negedge clk);

    // Back-to-back: second sample buffered during first frame
    send(12'h123, 3'd1, 1'b0);
    send(12'hFFF, 3'd3, 1'b0);
    check("ready_low_buffered", 32'(ready), 32'd0);
    capture(fr, rises, low, hi, first);
    check("frame_b2b_a", fr, 32'h00311230);
    check("b2b_a_cs_low", 32'(low), 32'd128);
    check("ready_during_a", 32'(ready), 32'd0);
    capture(fr, rises, low, hi, first);
    check("cs_gap", 32'(hi + 1), 32'd2);
    check("frame_b2b_b", fr, 32'h0033FFF0);
    check("b2b_b_rises", 32'(rises), 32'd32);
    check("ready_after_b", 32'(ready), 32'd1);
    check("busy_in_gap", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    check("busy_back_idle", 32'(busy), 32'd0);

    // Highest valid channel
    send(12'h800, 3'd4, 1'b0);
    capture(fr, rises, low, hi, first);
    check("frame_ch4", fr, 32'h00348000);

    // Out-of-range channel: accepted and dropped
    repeat (3) @(negedge clk);
    send(12'h555, 3'd5, 1'b0);
    check("ready_after_discard", 32'(ready), 32'd1);
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (cs !== 1'b1) cnt++;
    end
    check("discard_no_frame", 32'(cnt), 32'd0);
    check("discard_busy", 32'(busy), 32'd0);

    // Reset while bit 17 is on MOSI (15th SCK rise)
    send(12'h3C5, 3'd1, 1'b0);
    cnt = 0; rises = 0; low = 0;
    while (cs !== 1'b0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    while (rises < 15 && low < 200) begin
      @(negedge clk);
      low++;
      if (sck === 1'b1 && cnt != -1) rises++;
      while (sck === 1'b1 && low < 200) begin
        @(negedge clk);
        low++;
      end
    end
    check("abort_reached_bit17", 32'(rises), 32'd15);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    release_and_clear();
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (cs !== 1'b1) cnt++;
    end
    check("no_residual_frame", 32'(cnt), 32'd0);

    // Normal frame after recovery
    send(12'h000, 3'd0, 1'b0);
    capture(fr, rises, low, hi, first);
    check("frame_after_reset", fr, 32'h00300000);
    check("cs_low_after_reset", 32'(low), 32'd128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
